dds_wave_gen: RTL

DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

---
 rtl/dds_wave_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: phase accumulator, truncated phase
// with offset, four wave shapes, midscale attenuation, shadowed configuration.
module dds_wave_gen #(
  parameter int ACC_W   = 24,
  parameter int FREQ_W  = 12,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         wave_selector,
  input  logic [FREQ_W-1:0]  freq_ctl,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         amp_shift,
  input  logic               cfg_load,
  output logic               cfg_pending,
  output logic [OUT_W-1:0]   output_wave,
  output logic               sync_out
);
  localparam int SW = 2*PHASE_W + OUT_W;
  localparam logic [OUT_W-1:0] MID   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MIDM1 = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] FS    = {OUT_W{1'b1}};
  localparam logic [SW-1:0] H_SW     = {{(SW-PHASE_W){1'b0}}, 1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [SW-1:0] MIDM1_SW = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  typedef struct packed {
    logic [1:0]         sel;
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] off;
    logic [1:0]         amp;
  } cfg_t;

  cfg_t act, shd, cfg_in;
  assign cfg_in = '{sel: wave_selector, freq: freq_ctl, off: phase_off, amp: amp_shift};

  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum;
  logic [PHASE_W-1:0] ph;
  // wrp_pipe[0]: acc holds the first value after a wrap; [1]: ph was taken from it
  logic [1:0]         wrp_pipe;
  logic               commit;

  assign sum = {1'b0, acc} + {{(ACC_W-FREQ_W+1){1'b0}}, act.freq};
  // Committing while acc sits on its first post-wrap value lines the new sel up
  // with the first sample of the new cycle.
  assign commit = cfg_pending && ((en && wrp_pipe[0]) || (act.freq == '0));

  logic [PHASE_W-2:0] x;
  logic               msb;
  logic [PHASE_W-1:0] tri_v;
  logic [OUT_W-1:0]   saw_a, tri_a;
  assign x     = ph[PHASE_W-2:0];
  assign msb   = ph[PHASE_W-1];
  assign tri_v = {(msb ? ~x : x), 1'b0};

  generate
    if (OUT_W > PHASE_W) begin : g_zfill
      assign saw_a = {ph,    {(OUT_W-PHASE_W){1'b0}}};
      assign tri_a = {tri_v, {(OUT_W-PHASE_W){1'b0}}};
    end else begin : g_trunc
      assign saw_a = ph[PHASE_W-1 -: OUT_W];
      assign tri_a = tri_v[PHASE_W-1 -: OUT_W];
    end
  endgenerate

  logic [SW-1:0]         xe, q, s_full;
  logic [OUT_W-1:0]      sin_v, samp;
  logic signed [OUT_W:0] d, d_sh;
  logic [OUT_W:0]        atten;

  always_comb begin
    xe     = {{(SW-PHASE_W+1){1'b0}}, x};
    q      = xe * (H_SW - xe);
    // peak q is H^2/4 = 2^(2*PHASE_W-4), so s peaks at MID-1
    s_full = (q * MIDM1_SW) >> (2*PHASE_W-4);
    sin_v  = msb ? (MIDM1 - s_full[OUT_W-1:0]) : (MID + s_full[OUT_W-1:0]);
    samp   = sin_v;
    case (act.sel)
      2'd1:    samp = msb ? '0 : FS;
      2'd2:    samp = tri_a;
      2'd3:    samp = saw_a;
      default: samp = sin_v;
    endcase
    d     = $signed({1'b0, samp}) - $signed({1'b0, MID});
    d_sh  = d >>> act.amp;
    atten = {1'b0, MID} + d_sh;
  end

  logic unused_bits;
  assign unused_bits = ^{s_full[SW-1:OUT_W], atten[OUT_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      act         <= '0;
      shd         <= '0;
      cfg_pending <= 1'b0;
      acc         <= '0;
      ph          <= '0;
      wrp_pipe    <= '0;
      output_wave <= MID;
      sync_out    <= 1'b0;
    end else begin
      if (commit) act <= shd;
      if (cfg_load) begin
        shd         <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (commit) begin
        cfg_pending <= 1'b0;
      end
      if (en) begin
        acc         <= sum[ACC_W-1:0];
        ph          <= acc[ACC_W-1 -: PHASE_W] + act.off;
        wrp_pipe    <= {wrp_pipe[0], sum[ACC_W]};
        output_wave <= atten[OUT_W-1:0];
      end
      sync_out <= en & wrp_pipe[1];
    end
  end
endmodule
